// File: rtl/branch_update_queue.sv
// In-order queue of predicted branches awaiting resolution. Each resolution
// produces a one-cycle predictor update write and, on a mispredict, a redirect.
module branch_update_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        i_fetch_valid,
  input  logic [31:0] i_fetch_pc,
  input  logic [30:0] i_pred,
  output logic        o_fetch_ready,
  output logic [4:0]  o_addrr,
  input  logic        i_res_valid,
  input  logic        i_res_taken,
  input  logic [29:0] i_res_target,
  output logic        o_WE,
  output logic [4:0]  o_addrw,
  output logic [29:0] o_wdata,
  output logic        o_next,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_full,
  output logic        o_empty,
  output logic        o_underflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [31:0]   pc_q  [DEPTH];
  logic          tkn_q [DEPTH];
  logic [29:0]   tgt_q [DEPTH];

  logic [PW-1:0] rd_ptr, rd_ptr_next;
  logic [PW-1:0] wr_ptr, wr_ptr_next;
  logic [CW-1:0] count, count_next;

  logic          push, pop, mispredict;
  logic [31:0]   head_pc;
  logic          head_taken;
  logic [29:0]   head_tgt;

  assign o_full        = (count == CW'(DEPTH));
  assign o_empty       = (count == '0);
  assign o_fetch_ready = !o_full && !o_WE && Reset;
  // The predictor derives its new counter state from the read port, so the
  // read index must follow the write index during an update cycle.
  assign o_addrr       = o_WE ? o_addrw : i_fetch_pc[6:2];

  assign push = i_fetch_valid && o_fetch_ready;
  assign pop  = i_res_valid && !o_empty;

  assign head_pc    = pc_q[rd_ptr];
  assign head_taken = tkn_q[rd_ptr];
  assign head_tgt   = tgt_q[rd_ptr];

  always_comb begin
    mispredict = 1'b0;
    if (pop) begin
      mispredict = (head_taken != i_res_taken) ||
                   (head_taken && i_res_taken && (head_tgt != i_res_target));
    end
  end

  // A mispredict flushes everything, including any push in the same cycle.
  always_comb begin
    rd_ptr_next = rd_ptr;
    wr_ptr_next = wr_ptr;
    count_next  = count;
    if (mispredict) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) wr_ptr_next = wr_ptr + PW'(1);
      if (pop)  rd_ptr_next = rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count_next = count + CW'(1);
        2'b01:   count_next = count - CW'(1);
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      rd_ptr <= rd_ptr_next;
      wr_ptr <= wr_ptr_next;
      count  <= count_next;
    end
  end

  always_ff @(posedge Clk) begin
    if (push && !mispredict) begin
      pc_q[wr_ptr]  <= i_fetch_pc;
      tkn_q[wr_ptr] <= i_pred[0];
      tgt_q[wr_ptr] <= i_pred[30:1];
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      o_WE          <= 1'b0;
      o_addrw       <= '0;
      o_wdata       <= '0;
      o_next        <= 1'b0;
      o_redirect    <= 1'b0;
      o_redirect_pc <= '0;
      o_underflow   <= 1'b0;
    end else begin
      o_WE       <= pop;
      o_redirect <= mispredict;
      if (pop) begin
        o_addrw <= head_pc[6:2];
        o_next  <= i_res_taken;
        o_wdata <= i_res_taken ? i_res_target : head_tgt;
      end
      if (mispredict) begin
        o_redirect_pc <= i_res_taken ? {i_res_target, 2'b00} : head_pc + 32'd4;
      end
      if (i_res_valid && o_empty) begin
        o_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_update_queue.sv
// Directed self-checking bench for branch_update_queue (DEPTH = 4).
module tb_branch_update_queue;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        i_fetch_valid;
  logic [31:0] i_fetch_pc;
  logic [30:0] i_pred;
  logic        o_fetch_ready;
  logic [4:0]  o_addrr;
  logic        i_res_valid;
  logic        i_res_taken;
  logic [29:0] i_res_target;
  logic        o_WE;
  logic [4:0]  o_addrw;
  logic [29:0] o_wdata;
  logic        o_next;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;
  logic        o_full;
  logic        o_empty;
  logic        o_underflow;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  branch_update_queue #(.DEPTH(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .i_fetch_valid(i_fetch_valid), .i_fetch_pc(i_fetch_pc), .i_pred(i_pred),
    .o_fetch_ready(o_fetch_ready), .o_addrr(o_addrr),
    .i_res_valid(i_res_valid), .i_res_taken(i_res_taken), .i_res_target(i_res_target),
    .o_WE(o_WE), .o_addrw(o_addrw), .o_wdata(o_wdata), .o_next(o_next),
    .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc),
    .o_full(o_full), .o_empty(o_empty), .o_underflow(o_underflow)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        fv;
    logic [31:0] pc;
    logic [30:0] pred;
    logic        rv;
    logic        rt;
    logic [29:0] rtgt;
    logic        e_ready;
    logic [4:0]  e_addrr;
    logic        e_we;
    logic [4:0]  e_addrw;
    logic [29:0] e_wdata;
    logic        e_next;
    logic        e_redir;
    logic [31:0] e_rpc;
    logic        e_full;
    logic        e_empty;
    logic        e_uf;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [31:0] pc, input logic [30:0] pred,
                       input logic rv, input logic rt, input logic [29:0] rtgt);
    i_fetch_valid = fv;
    i_fetch_pc    = pc;
    i_pred        = pred;
    i_res_valid   = rv;
    i_res_taken   = rt;
    i_res_target  = rtgt;
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 32'h7C, 31'h0, 1'b0, 1'b0, 30'h0,
                 1'b1, 5'd31, 1'b0, 5'd0, 30'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 32'h40, 31'h201, 1'b0, 1'b0, 30'h0,
                 1'b1, 5'd16, 1'b0, 5'd0, 30'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 32'h0, 31'h0, 1'b1, 1'b1, 30'h100,
                 1'b1, 5'd0, 1'b0, 5'd0, 30'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 32'h7C, 31'h2, 1'b0, 1'b0, 30'h0,
                 1'b0, 5'd16, 1'b1, 5'd16, 30'h100, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 32'h44, 31'hAA, 1'b0, 1'b0, 30'h0,
                 1'b1, 5'd17, 1'b0, 5'd0, 30'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 32'h0, 31'h0, 1'b1, 1'b1, 30'h20,
                 1'b1, 5'd0, 1'b0, 5'd0, 30'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 32'h0, 31'h0, 1'b0, 1'b0, 30'h0,
                 1'b0, 5'd17, 1'b1, 5'd17, 30'h20, 1'b1, 1'b1, 32'h80, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 32'h48, {30'h1234567, 1'b1}, 1'b0, 1'b0, 30'h0,
                 1'b1, 5'd18, 1'b0, 5'd0, 30'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 32'h0, 31'h0, 1'b1, 1'b0, 30'h999,
                 1'b1, 5'd0, 1'b0, 5'd0, 30'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 32'h0, 31'h0, 1'b0, 1'b0, 30'h0,
                 1'b0, 5'd18, 1'b1, 5'd18, 30'h1234567, 1'b0, 1'b1, 32'h4C, 1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 32'h0, 31'h0, 1'b1, 1'b1, 30'h5,
                 1'b1, 5'd0, 1'b0, 5'd0, 30'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 32'h0, 31'h0, 1'b0, 1'b0, 30'h0,
                 1'b1, 5'd0, 1'b0, 5'd0, 30'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1};

    Reset = 1'b0;
    drive(1'b0, 32'h0, 31'h0, 1'b0, 1'b0, 30'h0);
    tick();
    tick();
    check("rst_we",       32'(o_WE), 32'd0);
    check("rst_redirect", 32'(o_redirect), 32'd0);
    check("rst_rpc",      o_redirect_pc, 32'd0);
    check("rst_addrw",    32'(o_addrw), 32'd0);
    check("rst_wdata",    32'(o_wdata), 32'd0);
    check("rst_next",     32'(o_next), 32'd0);
    check("rst_empty",    32'(o_empty), 32'd1);
    check("rst_full",     32'(o_full), 32'd0);
    check("rst_uf",       32'(o_underflow), 32'd0);
    check("rst_ready",    32'(o_fetch_ready), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    tick();

    // Table: each row's expectations hold just before the edge that samples its inputs.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].fv, vecs[i].pc, vecs[i].pred, vecs[i].rv, vecs[i].rt, vecs[i].rtgt);
      #1;
      check($sformatf("v%0d_ready", i), 32'(o_fetch_ready), 32'(vecs[i].e_ready));
      check($sformatf("v%0d_addrr", i), 32'(o_addrr), 32'(vecs[i].e_addrr));
      check($sformatf("v%0d_we", i), 32'(o_WE), 32'(vecs[i].e_we));
      check($sformatf("v%0d_redirect", i), 32'(o_redirect), 32'(vecs[i].e_redir));
      check($sformatf("v%0d_full", i), 32'(o_full), 32'(vecs[i].e_full));
      check($sformatf("v%0d_empty", i), 32'(o_empty), 32'(vecs[i].e_empty));
      check($sformatf("v%0d_uf", i), 32'(o_underflow), 32'(vecs[i].e_uf));
      if (vecs[i].e_we) begin
        check($sformatf("v%0d_addrw", i), 32'(o_addrw), 32'(vecs[i].e_addrw));
        check($sformatf("v%0d_wdata", i), 32'(o_wdata), 32'(vecs[i].e_wdata));
        check($sformatf("v%0d_next", i), 32'(o_next), 32'(vecs[i].e_next));
      end
      if (vecs[i].e_redir) begin
        check($sformatf("v%0d_rpc", i), o_redirect_pc, vecs[i].e_rpc);
      end
      tick();
    end

    // Fill to DEPTH, then pop with a simultaneous (refused) fetch.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 32'h100 + 32'(4 * k), {30'h40 + 30'(k), 1'b0}, 1'b0, 1'b0, 30'h0);
      tick();
    end
    drive(1'b1, 32'h110, {30'h44, 1'b0}, 1'b0, 1'b0, 30'h0);
    #1;
    check("full_flag",  32'(o_full), 32'd1);
    check("full_ready", 32'(o_fetch_ready), 32'd0);
    tick();
    check("full_hold",  32'(o_full), 32'd1);
    drive(1'b1, 32'h110, {30'h44, 1'b0}, 1'b1, 1'b0, 30'h0);
    tick();
    check("fpop_full",  32'(o_full), 32'd0);
    check("fpop_empty", 32'(o_empty), 32'd0);
    check("fpop_we",    32'(o_WE), 32'd1);
    check("fpop_addrw", 32'(o_addrw), 32'd0);
    check("fpop_wdata", 32'(o_wdata), 32'h40);
    check("fpop_redir", 32'(o_redirect), 32'd0);
    for (int k = 1; k < 4; k++) begin
      drive(1'b0, 32'h0, 31'h0, 1'b1, 1'b0, 30'h0);
      tick();
      check($sformatf("drain%0d_we", k), 32'(o_WE), 32'd1);
      check($sformatf("drain%0d_addrw", k), 32'(o_addrw), 32'(k));
      check($sformatf("drain%0d_wdata", k), 32'(o_wdata), 32'h40 + 32'(k));
    end
    check("drain_empty", 32'(o_empty), 32'd1);
    drive(1'b0, 32'h0, 31'h0, 1'b0, 1'b0, 30'h0);
    tick();

    // Correct pop with same-cycle push keeps the count at one.
    drive(1'b1, 32'h200, {30'h80, 1'b0}, 1'b0, 1'b0, 30'h0);
    tick();
    drive(1'b1, 32'h204, {30'h81, 1'b0}, 1'b1, 1'b0, 30'h0);
    #1;
    check("pp_ready", 32'(o_fetch_ready), 32'd1);
    tick();
    check("pp_empty", 32'(o_empty), 32'd0);
    check("pp_addrw", 32'(o_addrw), 32'd0);
    check("pp_wdata", 32'(o_wdata), 32'h80);
    drive(1'b0, 32'h0, 31'h0, 1'b1, 1'b0, 30'h0);
    tick();
    check("pp2_addrw", 32'(o_addrw), 32'd1);
    check("pp2_wdata", 32'(o_wdata), 32'h81);
    check("pp2_empty", 32'(o_empty), 32'd1);
    drive(1'b0, 32'h0, 31'h0, 1'b0, 1'b0, 30'h0);
    tick();

    // Mispredict flush drops the queued entry and the same-cycle push.
    drive(1'b1, 32'h300, {30'hC0, 1'b0}, 1'b0, 1'b0, 30'h0);
    tick();
    drive(1'b1, 32'h304, {30'hC1, 1'b0}, 1'b0, 1'b0, 30'h0);
    tick();
    drive(1'b1, 32'h308, {30'hC2, 1'b0}, 1'b1, 1'b1, 30'h10);
    tick();
    check("flush_redir", 32'(o_redirect), 32'd1);
    check("flush_rpc",   o_redirect_pc, 32'h40);
    check("flush_wdata", 32'(o_wdata), 32'h10);
    check("flush_next",  32'(o_next), 32'd1);
    check("flush_empty", 32'(o_empty), 32'd1);
    drive(1'b0, 32'h0, 31'h0, 1'b0, 1'b0, 30'h0);
    tick();
    check("flush_empty2", 32'(o_empty), 32'd1);
    check("flush_redir2", 32'(o_redirect), 32'd0);

    // Both taken with differing targets is a mispredict.
    drive(1'b1, 32'h500, {30'h200, 1'b1}, 1'b0, 1'b0, 30'h0);
    tick();
    drive(1'b0, 32'h0, 31'h0, 1'b1, 1'b1, 30'h201);
    tick();
    check("tgt_redir", 32'(o_redirect), 32'd1);
    check("tgt_rpc",   o_redirect_pc, 32'h804);
    check("tgt_addrw", 32'(o_addrw), 32'h0);
    drive(1'b0, 32'h0, 31'h0, 1'b0, 1'b0, 30'h0);
    tick();

    // Asynchronous reset mid-update clears the pending write and sticky error.
    drive(1'b1, 32'h600, {30'h11, 1'b1}, 1'b0, 1'b0, 30'h0);
    tick();
    drive(1'b0, 32'h0, 31'h0, 1'b1, 1'b1, 30'h11);
    tick();
    check("pre_rst_we", 32'(o_WE), 32'd1);
    check("pre_rst_uf", 32'(o_underflow), 32'd1);
    drive(1'b0, 32'h0, 31'h0, 1'b0, 1'b0, 30'h0);
    #2;
    Reset = 1'b0;
    #1;
    check("arst_we",    32'(o_WE), 32'd0);
    check("arst_uf",    32'(o_underflow), 32'd0);
    check("arst_empty", 32'(o_empty), 32'd1);
    check("arst_addrw", 32'(o_addrw), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      check($sformatf("post_rst%0d_we", k), 32'(o_WE), 32'd0);
      check($sformatf("post_rst%0d_redir", k), 32'(o_redirect), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/branch_update_queue.md
BRANCH_UPDATE_QUEUE -- requirements
Module: branch_update_queue

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the number of in-flight predicted branches (power of two, 2..16).
REQ-002 Clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 i_fetch_valid  input  1  SHALL indicate that fetch presents a branch for lookup/enqueue this cycle.
REQ-005 i_fetch_pc  input  32  SHALL be the branch PC; bits [6:2] form the predictor index.
REQ-006 i_pred  input  31  SHALL be the predictor output {target[29:0], taken} for o_addrr.
REQ-007 o_fetch_ready  output  1  SHALL indicate that a fetch branch is accepted this cycle.
REQ-008 o_addrr  output  5  SHALL be the predictor read index.
REQ-009 i_res_valid  input  1  SHALL indicate that execute resolves the oldest queued branch.
REQ-010 i_res_taken  input  1  SHALL be the actual branch direction.
REQ-011 i_res_target  input  30  SHALL be the actual taken-target word address.
REQ-012 o_WE, o_addrw[4:0], o_wdata[29:0], o_next  outputs  SHALL be the predictor update write (WE, i_addrw, i_data, i_next).
REQ-013 o_redirect  output  1 and o_redirect_pc  output  32  SHALL signal a mispredict and the correct fetch PC.
REQ-014 o_full, o_empty  outputs  1  SHALL reflect queue occupancy; o_underflow  output  1  SHALL be a sticky error flag.

Function
REQ-015 Queue entry SHALL hold {pc[31:0], pred_taken, pred_target[29:0]}; FIFO, in-order resolution.
REQ-016 o_fetch_ready SHALL equal !o_full && !o_WE && Reset.
REQ-017 o_addrr SHALL equal o_addrw while o_WE=1, else i_fetch_pc[6:2] (combinational); the predictor computes new counter state from the read port, so the read and write indices must match during an update.
REQ-018 Push SHALL occur on i_fetch_valid && o_fetch_ready, capturing i_fetch_pc and i_pred.
REQ-019 Pop SHALL occur on i_res_valid && !o_empty.
REQ-020 One cycle after a pop, the block SHALL pulse o_WE=1 for exactly one cycle with the following values:
- o_addrw = entry pc[6:2]
- o_next = i_res_taken
- o_wdata = i_res_target if taken, else entry pred_target.
REQ-021 A mispredict SHALL be defined as: (pred_taken != i_res_taken) or (both taken and pred_target != i_res_target).
REQ-022 On a mispredict pop, one cycle later (same cycle as o_WE), the block SHALL pulse o_redirect=1 for one cycle with o_redirect_pc set as follows:
- {i_res_target,2'b00} if taken
- entry pc+4 otherwise, modulo 2^32.
REQ-023 On a mispredict pop, all queue entries SHALL be discarded at that edge (pointers and count to 0), and any same-cycle push SHALL be dropped.
REQ-024 On a correct pop with a same-cycle push, both SHALL take effect and the count SHALL be unchanged.
REQ-025 When full, a push SHALL be refused even if a pop occurs in the same cycle.
REQ-026 i_res_valid while o_empty SHALL set o_underflow=1 (held until reset), with no write and no redirect.
REQ-027 Pointers SHALL wrap modulo DEPTH; the count SHALL range 0..DEPTH.
REQ-028 o_full SHALL be (count==DEPTH) and o_empty SHALL be (count==0), both registered-state derived.

Reset
REQ-029 Reset low SHALL immediately and asynchronously clear pointers, count, o_WE, o_redirect, o_redirect_pc, o_addrw, o_wdata, o_next and o_underflow to 0, giving o_empty=1 and o_full=0.
REQ-030 Reset asserted mid-operation SHALL abort any pending update or redirect; no o_WE pulse SHALL follow deassertion.

Verification
REQ-031 Push pc=0x40 with i_pred={0x0000100,1}, then resolve taken with target 0x0000100 -> next cycle o_WE=1, o_addrw=16, o_wdata=0x0000100, o_next=1, o_redirect=0.
REQ-032 Push pc=0x44 predicted not-taken, then resolve taken with target 0x20 -> o_redirect=1, o_redirect_pc=0x80, o_empty=1 the following cycle.
REQ-033 Push pc=0x48 predicted taken, then resolve not-taken -> o_redirect_pc=0x4C, o_wdata equals the stored pred_target, o_next=0.
REQ-034 Push DEPTH branches -> o_full=1 and o_fetch_ready=0; a pop with a simultaneous fetch leaves count=DEPTH-1 with the push refused.
REQ-035 During an o_WE cycle with i_fetch_pc=0x7C -> o_addrr=o_addrw (not 31) and o_fetch_ready=0.
REQ-036 i_res_valid on an empty queue -> o_underflow=1, o_WE stays 0; then Reset low -> o_underflow=0.
